mmu_bus_arbiter: RTL and testbench

- Shares the single memory-side bus port inside the MMU between three requesters: instruction fetch read, data read, and data write.
- Serialises one transaction at a time through a 3-state FSM.
- Enforces fixed priority with an anti-starvation counter for fetch.
- Drops fetch responses cancelled by a pipeline flush, and drives MEM_WAIT back to the core.

---
 rtl/mmu_bus_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mmu_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_bus_arbiter
//
// Shares the single memory-side bus port of the MMU between three requesters:
// instruction fetch (read), data load (read) and data store (write). One
// transaction is in flight at a time, sequenced by a three-state FSM
// (IDLE -> ADDR -> [RDATA] -> IDLE).
//
// Handshakes: a requester raises *_REQ with its payload and holds both until
// the matching ACK pulse. The arbiter raises BUS_REQ with a latched payload
// and holds it until BUS_READY. For reads, BUS_RVALID is accepted only in
// RDATA. Every ACK is a combinational one-cycle pulse in the completing bus
// cycle, so the requester drops REQ before the following IDLE cycle. That
// IDLE cycle is also why back-to-back grants are one cycle apart.
//
// Priority in IDLE: store > load > fetch. If fetch has been passed over
// STARVE_LIMIT times in a row while requesting, fetch wins instead.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   INST_REQ/ADDR/CANCEL           fetch request, address and pipeline flush
//   INST_ACK/RADDR/RDATA           fetch completion pulse, address and data
//   DATA_RREQ/RADDR                load request and address
//   DATA_RACK/RDATA                load completion pulse and data
//   DATA_WREQ/WADDR/WSTRB/WDATA    store request and payload
//   DATA_WACK                      store accepted by the bus
//   BUS_REQ/WE/ADDR/STRB/WDATA     bus request and latched payload
//   BUS_READY, BUS_RVALID/RDATA    bus accept and read return
//   MEM_WAIT                       arbiter busy (state != IDLE)
//   DBG_STATE, DBG_STARVE          FSM state and starvation counter
// -----------------------------------------------------------------------------
module mmu_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    INST_REQ,
    input  logic [ADDR_WIDTH-1:0]   INST_ADDR,
    input  logic                    INST_CANCEL,
    output logic                    INST_ACK,
    output logic [ADDR_WIDTH-1:0]   INST_RADDR,
    output logic [DATA_WIDTH-1:0]   INST_RDATA,
    input  logic                    DATA_RREQ,
    input  logic [ADDR_WIDTH-1:0]   DATA_RADDR,
    output logic                    DATA_RACK,
    output logic [DATA_WIDTH-1:0]   DATA_RDATA,
    input  logic                    DATA_WREQ,
    input  logic [ADDR_WIDTH-1:0]   DATA_WADDR,
    input  logic [DATA_WIDTH/8-1:0] DATA_WSTRB,
    input  logic [DATA_WIDTH-1:0]   DATA_WDATA,
    output logic                    DATA_WACK,
    output logic                    BUS_REQ,
    output logic                    BUS_WE,
    output logic [ADDR_WIDTH-1:0]   BUS_ADDR,
    output logic [DATA_WIDTH/8-1:0] BUS_STRB,
    output logic [DATA_WIDTH-1:0]   BUS_WDATA,
    input  logic                    BUS_READY,
    input  logic                    BUS_RVALID,
    input  logic [DATA_WIDTH-1:0]   BUS_RDATA,
    output logic                    MEM_WAIT,
    output logic [1:0]              DBG_STATE,
    output logic [3:0]              DBG_STARVE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DRD  = 2'd2;
    localparam logic [1:0] OWN_DWR  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                    state;
    state_t                    state_next;
    logic [1:0]                owner;
    logic [3:0]                starve_cnt;
    logic                      cancel_flag;
    logic [ADDR_WIDTH-1:0]     bus_addr_q;
    logic [DATA_WIDTH/8-1:0]   bus_strb_q;
    logic [DATA_WIDTH-1:0]     bus_wdata_q;
    logic                      bus_we_q;
    logic [ADDR_WIDTH-1:0]     inst_raddr_q;
    logic [DATA_WIDTH-1:0]     inst_rdata_q;
    logic [DATA_WIDTH-1:0]     data_rdata_q;

    // Grant decode, only acted upon in IDLE. A flush in the same cycle
    // blocks the fetch grant, even a forced one.
    logic fetch_ok;
    logic force_fetch;
    logic grant_wr;
    logic grant_rd;
    logic grant_inst;
    logic any_grant;

    assign fetch_ok    = INST_REQ && !INST_CANCEL;
    assign force_fetch = fetch_ok && (starve_cnt == LIMIT);
    assign grant_wr    = !force_fetch && DATA_WREQ;
    assign grant_rd    = !force_fetch && !DATA_WREQ && DATA_RREQ;
    assign grant_inst  = force_fetch || (fetch_ok && !DATA_WREQ && !DATA_RREQ);
    assign any_grant   = grant_wr || grant_rd || grant_inst;

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_grant) state_next = S_ADDR;
            S_ADDR:  if (BUS_READY) state_next = bus_we_q ? S_IDLE : S_RDATA;
            S_RDATA: if (BUS_RVALID) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Completion pulses are masked while RST is high so that a transaction
    // abandoned by reset never acknowledges.
    always_comb begin
        BUS_REQ   = 1'b0;
        MEM_WAIT  = 1'b0;
        DATA_WACK = 1'b0;
        INST_ACK  = 1'b0;
        DATA_RACK = 1'b0;
        case (state)
            S_ADDR: begin
                BUS_REQ   = 1'b1;
                MEM_WAIT  = 1'b1;
                DATA_WACK = !RST && BUS_READY && bus_we_q;
            end
            S_RDATA: begin
                MEM_WAIT  = 1'b1;
                INST_ACK  = !RST && BUS_RVALID && (owner == OWN_INST)
                            && !cancel_flag && !INST_CANCEL;
                DATA_RACK = !RST && BUS_RVALID && (owner == OWN_DRD);
            end
            default: ;
        endcase
    end

    // Read data is visible in the ACK cycle itself and held afterwards.
    assign INST_RDATA = INST_ACK  ? BUS_RDATA  : inst_rdata_q;
    assign INST_RADDR = INST_ACK  ? bus_addr_q : inst_raddr_q;
    assign DATA_RDATA = DATA_RACK ? BUS_RDATA  : data_rdata_q;

    assign BUS_WE     = bus_we_q;
    assign BUS_ADDR   = bus_addr_q;
    assign BUS_STRB   = bus_strb_q;
    assign BUS_WDATA  = bus_wdata_q;
    assign DBG_STATE  = state;
    assign DBG_STARVE = starve_cnt;

    // ---------------- datapath and bookkeeping ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner        <= OWN_NONE;
            starve_cnt   <= '0;
            cancel_flag  <= 1'b0;
            bus_addr_q   <= '0;
            bus_strb_q   <= '0;
            bus_wdata_q  <= '0;
            bus_we_q     <= 1'b0;
            inst_raddr_q <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            if (state == S_IDLE) begin
                cancel_flag <= 1'b0;
                if (grant_wr) begin
                    owner       <= OWN_DWR;
                    bus_we_q    <= 1'b1;
                    bus_addr_q  <= DATA_WADDR;
                    bus_strb_q  <= DATA_WSTRB;
                    bus_wdata_q <= DATA_WDATA;
                end else if (grant_rd) begin
                    owner       <= OWN_DRD;
                    bus_we_q    <= 1'b0;
                    bus_addr_q  <= DATA_RADDR;
                    bus_strb_q  <= '1;
                    bus_wdata_q <= '0;
                end else if (grant_inst) begin
                    owner       <= OWN_INST;
                    bus_we_q    <= 1'b0;
                    bus_addr_q  <= INST_ADDR;
                    bus_strb_q  <= '1;
                    bus_wdata_q <= '0;
                end

                // Counts data grants that bypassed a waiting fetch.
                if (grant_inst) begin
                    starve_cnt <= '0;
                end else if ((grant_wr || grant_rd) && INST_REQ) begin
                    if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
                end else if (!INST_REQ) begin
                    starve_cnt <= '0;
                end
            end else if ((owner == OWN_INST) && INST_CANCEL) begin
                // The bus transfer still completes; only the response is dropped.
                cancel_flag <= 1'b1;
            end

            if (INST_ACK) begin
                inst_rdata_q <= BUS_RDATA;
                inst_raddr_q <= bus_addr_q;
            end
            if (DATA_RACK) begin
                data_rdata_q <= BUS_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmu_bus_arbiter
//
// Directed bench for mmu_bus_arbiter. The bus side is driven by hand, one
// cycle at a time. Inputs change 1 ns after the rising edge. Outputs are
// checked 1-2 ns after the edge. ACK pulses are also counted on the falling
// edge, so "exactly one ACK" can be stated per scenario.
// -----------------------------------------------------------------------------
module tb_mmu_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            CLK;
    logic            RST;
    logic            INST_REQ;
    logic [AW-1:0]   INST_ADDR;
    logic            INST_CANCEL;
    logic            INST_ACK;
    logic [AW-1:0]   INST_RADDR;
    logic [DW-1:0]   INST_RDATA;
    logic            DATA_RREQ;
    logic [AW-1:0]   DATA_RADDR;
    logic            DATA_RACK;
    logic [DW-1:0]   DATA_RDATA;
    logic            DATA_WREQ;
    logic [AW-1:0]   DATA_WADDR;
    logic [DW/8-1:0] DATA_WSTRB;
    logic [DW-1:0]   DATA_WDATA;
    logic            DATA_WACK;
    logic            BUS_REQ;
    logic            BUS_WE;
    logic [AW-1:0]   BUS_ADDR;
    logic [DW/8-1:0] BUS_STRB;
    logic [DW-1:0]   BUS_WDATA;
    logic            BUS_READY;
    logic            BUS_RVALID;
    logic [DW-1:0]   BUS_RDATA;
    logic            MEM_WAIT;
    logic [1:0]      DBG_STATE;
    logic [3:0]      DBG_STARVE;

    int n_tests = 0;
    int n_fail  = 0;
    int n_inst_ack = 0;
    int n_rack = 0;
    int n_wack = 0;
    int base_i, base_r, base_w;

    mmu_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .INST_REQ(INST_REQ), .INST_ADDR(INST_ADDR), .INST_CANCEL(INST_CANCEL),
        .INST_ACK(INST_ACK), .INST_RADDR(INST_RADDR), .INST_RDATA(INST_RDATA),
        .DATA_RREQ(DATA_RREQ), .DATA_RADDR(DATA_RADDR),
        .DATA_RACK(DATA_RACK), .DATA_RDATA(DATA_RDATA),
        .DATA_WREQ(DATA_WREQ), .DATA_WADDR(DATA_WADDR), .DATA_WSTRB(DATA_WSTRB),
        .DATA_WDATA(DATA_WDATA), .DATA_WACK(DATA_WACK),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_STRB(BUS_STRB), .BUS_WDATA(BUS_WDATA),
        .BUS_READY(BUS_READY), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA),
        .MEM_WAIT(MEM_WAIT), .DBG_STATE(DBG_STATE), .DBG_STARVE(DBG_STARVE)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- ACK pulse counters ----------------
    always @(negedge CLK) begin
        if (INST_ACK)  n_inst_ack++;
        if (DATA_RACK) n_rack++;
        if (DATA_WACK) n_wack++;
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Entered in an IDLE cycle whose request inputs produce a read grant.
    // Runs ADDR (zero-wait READY) and RDATA, and returns in the following
    // IDLE cycle, leaving time for the caller to drop its request.
    task automatic bus_read(input string tag, input logic [31:0] exp_addr,
                            input logic [3:0] exp_cnt, input logic [31:0] rdata);
        cyc();
        check({tag, "_busreq"}, 64'(BUS_REQ), 64'd1);
        check({tag, "_addr"}, 64'(BUS_ADDR), 64'(exp_addr));
        check({tag, "_starve"}, 64'(DBG_STARVE), 64'(exp_cnt));
        BUS_READY = 1'b1;
        cyc();
        BUS_READY  = 1'b0;
        BUS_RVALID = 1'b1;
        BUS_RDATA  = rdata;
        cyc();
        BUS_RVALID = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST = 1'b1;
        INST_REQ = 1'b0; INST_ADDR = '0; INST_CANCEL = 1'b0;
        DATA_RREQ = 1'b0; DATA_RADDR = '0;
        DATA_WREQ = 1'b0; DATA_WADDR = '0; DATA_WSTRB = '0; DATA_WDATA = '0;
        BUS_READY = 1'b0; BUS_RVALID = 1'b0; BUS_RDATA = '0;

        // ---- reset state ----
        cyc();
        cyc();
        RST = 1'b0;
        #1;
        check("rst_state", 64'(DBG_STATE), 64'd0);
        check("rst_memwait", 64'(MEM_WAIT), 64'd0);
        check("rst_busreq", 64'(BUS_REQ), 64'd0);
        check("rst_busaddr", 64'(BUS_ADDR), 64'd0);
        check("rst_instrdata", 64'(INST_RDATA), 64'd0);
        check("rst_starve", 64'(DBG_STARVE), 64'd0);

        // ---- single fetch ----
        INST_REQ = 1'b1; INST_ADDR = 32'h2000_0000;
        #1;
        check("f1_c0_memwait", 64'(MEM_WAIT), 64'd0);
        cyc();
        check("f1_c1_busreq", 64'(BUS_REQ), 64'd1);
        check("f1_c1_addr", 64'(BUS_ADDR), 64'h2000_0000);
        check("f1_c1_we", 64'(BUS_WE), 64'd0);
        check("f1_c1_strb", 64'(BUS_STRB), 64'hF);
        check("f1_c1_memwait", 64'(MEM_WAIT), 64'd1);
        BUS_READY = 1'b1;
        cyc();
        BUS_READY = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'h0000_0013;
        #1;
        check("f1_c2_ack", 64'(INST_ACK), 64'd1);
        check("f1_c2_rdata", 64'(INST_RDATA), 64'h13);
        check("f1_c2_raddr", 64'(INST_RADDR), 64'h2000_0000);
        check("f1_c2_memwait", 64'(MEM_WAIT), 64'd1);
        check("f1_c2_busreq", 64'(BUS_REQ), 64'd0);
        INST_REQ = 1'b0;
        cyc();
        BUS_RVALID = 1'b0;
        #1;
        check("f1_c3_ack", 64'(INST_ACK), 64'd0);
        check("f1_c3_memwait", 64'(MEM_WAIT), 64'd0);
        check("f1_c3_rdata_hold", 64'(INST_RDATA), 64'h13);

        // ---- simultaneous store / load / fetch ----
        base_i = n_inst_ack; base_r = n_rack; base_w = n_wack;
        DATA_WREQ = 1'b1; DATA_WADDR = 32'h100; DATA_WSTRB = 4'hF; DATA_WDATA = 32'hDEAD_BEEF;
        DATA_RREQ = 1'b1; DATA_RADDR = 32'h200;
        INST_REQ  = 1'b1; INST_ADDR  = 32'h3000;
        cyc();
        check("pri_w_we", 64'(BUS_WE), 64'd1);
        check("pri_w_addr", 64'(BUS_ADDR), 64'h100);
        check("pri_w_strb", 64'(BUS_STRB), 64'hF);
        check("pri_w_wdata", 64'(BUS_WDATA), 64'hDEAD_BEEF);
        check("pri_w_starve", 64'(DBG_STARVE), 64'd1);
        BUS_READY = 1'b1;
        #1;
        check("pri_w_wack", 64'(DATA_WACK), 64'd1);
        DATA_WREQ = 1'b0;
        cyc();
        BUS_READY = 1'b0;
        #1;
        check("pri_gap_wack", 64'(DATA_WACK), 64'd0);
        check("pri_gap_state", 64'(DBG_STATE), 64'd0);
        bus_read("pri_ld", 32'h200, 4'd2, 32'hAAAA_5555);
        DATA_RREQ = 1'b0;
        #1;
        check("pri_ld_rdata", 64'(DATA_RDATA), 64'hAAAA_5555);
        bus_read("pri_if", 32'h3000, 4'd0, 32'h0000_0077);
        INST_REQ = 1'b0;
        #1;
        check("pri_if_rdata", 64'(INST_RDATA), 64'h77);
        check("pri_if_raddr", 64'(INST_RADDR), 64'h3000);
        check("pri_n_wack", 64'(n_wack - base_w), 64'd1);
        check("pri_n_rack", 64'(n_rack - base_r), 64'd1);
        check("pri_n_iack", 64'(n_inst_ack - base_i), 64'd1);

        // ---- starvation: 4 data grants, then fetch forced ----
        base_i = n_inst_ack; base_r = n_rack;
        INST_REQ = 1'b1; INST_ADDR = 32'h4000;
        DATA_RREQ = 1'b1; DATA_RADDR = 32'h500;
        for (int i = 0; i < 4; i++) begin
            bus_read("stv_ld", 32'h500, 4'(i + 1), 32'h50 + 32'(i));
        end
        bus_read("stv_if", 32'h4000, 4'd0, 32'h0000_0044);
        INST_REQ = 1'b0; DATA_RREQ = 1'b0;
        #1;
        check("stv_n_rack", 64'(n_rack - base_r), 64'd4);
        check("stv_n_iack", 64'(n_inst_ack - base_i), 64'd1);
        check("stv_ld_rdata", 64'(DATA_RDATA), 64'h53);
        check("stv_if_rdata", 64'(INST_RDATA), 64'h44);

        // ---- cancel: blocked in IDLE, then flushed during RDATA ----
        base_i = n_inst_ack; base_r = n_rack;
        cyc();
        INST_REQ = 1'b1; INST_ADDR = 32'h2000_0040; INST_CANCEL = 1'b1;
        cyc();
        check("cxl_idle_block", 64'(DBG_STATE), 64'd0);
        check("cxl_idle_memwait", 64'(MEM_WAIT), 64'd0);
        INST_CANCEL = 1'b0;
        cyc();
        check("cxl_addr", 64'(BUS_ADDR), 64'h2000_0040);
        BUS_READY = 1'b1;
        cyc();
        BUS_READY = 1'b0; INST_CANCEL = 1'b1;
        cyc();
        INST_CANCEL = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'h1234_5678;
        #1;
        check("cxl_ack", 64'(INST_ACK), 64'd0);
        check("cxl_rdata", 64'(INST_RDATA), 64'h44);
        check("cxl_memwait", 64'(MEM_WAIT), 64'd1);
        INST_REQ = 1'b0;
        cyc();
        BUS_RVALID = 1'b0;
        #1;
        check("cxl_idle", 64'(DBG_STATE), 64'd0);
        check("cxl_rdata_hold", 64'(INST_RDATA), 64'h44);
        check("cxl_raddr_hold", 64'(INST_RADDR), 64'h4000);
        DATA_RREQ = 1'b1; DATA_RADDR = 32'h600;
        bus_read("cxl_ld", 32'h600, 4'd0, 32'h0000_0066);
        DATA_RREQ = 1'b0;
        #1;
        check("cxl_ld_rdata", 64'(DATA_RDATA), 64'h66);
        check("cxl_n_rack", 64'(n_rack - base_r), 64'd1);
        check("cxl_n_iack", 64'(n_inst_ack - base_i), 64'd0);

        // ---- wait states on a store ----
        base_w = n_wack;
        DATA_WREQ = 1'b1; DATA_WADDR = 32'h700; DATA_WSTRB = 4'h3; DATA_WDATA = 32'hCAFE_F00D;
        cyc();
        // Requester payload moves after grant; the latched copy must not.
        DATA_WADDR = 32'hFFF; DATA_WDATA = 32'h0; DATA_WSTRB = 4'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ws_busreq", 64'(BUS_REQ), 64'd1);
            check("ws_addr", 64'(BUS_ADDR), 64'h700);
            check("ws_wdata", 64'(BUS_WDATA), 64'hCAFE_F00D);
            check("ws_wack_early", 64'(DATA_WACK), 64'd0);
            cyc();
        end
        BUS_READY = 1'b1;
        #1;
        check("ws_wack", 64'(DATA_WACK), 64'd1);
        check("ws_strb", 64'(BUS_STRB), 64'h3);
        DATA_WREQ = 1'b0;
        cyc();
        BUS_READY = 1'b0;
        #1;
        check("ws_wack_after", 64'(DATA_WACK), 64'd0);
        check("ws_memwait_after", 64'(MEM_WAIT), 64'd0);
        check("ws_n_wack", 64'(n_wack - base_w), 64'd1);

        // ---- reset in the middle of a read ----
        base_r = n_rack;
        DATA_RREQ = 1'b1; DATA_RADDR = 32'h800;
        cyc();
        BUS_READY = 1'b1;
        cyc();
        BUS_READY = 1'b0; DATA_RREQ = 1'b0;
        check("mrst_in_rdata", 64'(DBG_STATE), 64'd2);
        RST = 1'b1; BUS_RVALID = 1'b1; BUS_RDATA = 32'h0000_0099;
        #1;
        check("mrst_rack_in_rst", 64'(DATA_RACK), 64'd0);
        cyc();
        RST = 1'b0;
        #1;
        check("mrst_state", 64'(DBG_STATE), 64'd0);
        check("mrst_rack_late", 64'(DATA_RACK), 64'd0);
        check("mrst_drdata", 64'(DATA_RDATA), 64'd0);
        check("mrst_irdata", 64'(INST_RDATA), 64'd0);
        check("mrst_iraddr", 64'(INST_RADDR), 64'd0);
        check("mrst_busaddr", 64'(BUS_ADDR), 64'd0);
        check("mrst_buswdata", 64'(BUS_WDATA), 64'd0);
        check("mrst_memwait", 64'(MEM_WAIT), 64'd0);
        cyc();
        BUS_RVALID = 1'b0;
        #1;
        check("mrst_still_idle", 64'(DBG_STATE), 64'd0);
        DATA_RREQ = 1'b1; DATA_RADDR = 32'h900;
        bus_read("mrst_ld", 32'h900, 4'd0, 32'h0000_00AB);
        DATA_RREQ = 1'b0;
        #1;
        check("mrst_ld_rdata", 64'(DATA_RDATA), 64'hAB);
        check("mrst_n_rack", 64'(n_rack - base_r), 64'd1);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
